// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and sizing helper for the binary-to-BCD converter
package bcd_pkg;

  // Conversion sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One packed decimal digit
  typedef logic [3:0] bcd_digit_t;

  // True when DIGITS decimal digits can represent every BIN_W-bit unsigned value,
  // i.e. 10^digits >= 2^bin_w. Wide arithmetic keeps this exact for practical sizes.
  function automatic bit bcd_fits(input int bin_w, input int digits);
    logic [127:0] p10;
    logic [127:0] p2;
    p10 = 128'd1;
    for (int i = 0; i < digits; i++) begin
      p10 = p10 * 128'd10;
    end
    p2 = 128'd1 << bin_w;
    return (p10 >= p2);
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble nibble correction (add 3 when the digit is 5 or more)
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t din_i,
  output bcd_digit_t dout_o
);

  // A digit of 5..9 becomes 8..12 so that the following left shift carries into the next digit
  always_comb begin
    dout_o = din_i;
    if (din_i >= 4'd5) begin
      dout_o = din_i + 4'd3;
    end
  end

endmodule

// File: rtl/binary_to_bcd.sv
// rtl/binary_to_bcd.sv - sequential shift-and-add-3 binary to BCD converter with leading-zero blanking
module binary_to_bcd
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  out_valid
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W - 1);

  // Refuse to build a converter whose digits cannot hold the largest input
  if (!bcd_fits(BIN_W, DIGITS)) begin : g_size_check
    $error("binary_to_bcd: DIGITS too small for BIN_W");
  end

  state_t             state_q;
  logic [BIN_W-1:0]   shift_q;
  logic [BCD_W-1:0]   work_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [DIGITS-1:0]  en_q;
  logic               ready_q;
  logic               valid_q;

  logic [BCD_W-1:0]         corr;
  logic [BCD_W+BIN_W-1:0]   shifted;
  logic [BCD_W-1:0]         work_d;
  logic [BIN_W-1:0]         shift_d;
  logic [DIGITS-1:0]        en_d;

  // Per-digit correction of the working register before each shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din_i  (work_q[4*g +: 4]),
      .dout_o (corr[4*g +: 4])
    );
  end

  // One double-dabble step: corrected digits and remaining binary bits move left together
  always_comb begin
    shifted = {corr, shift_q} << 1;
    work_d  = shifted[BCD_W+BIN_W-1:BIN_W];
    shift_d = shifted[BIN_W-1:0];
  end

  // Digit i is shown when it or any more significant digit is nonzero; units always shown
  always_comb begin
    logic any_nz;
    any_nz = 1'b0;
    en_d   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any_nz  = any_nz | (work_d[4*i +: 4] != 4'd0);
      en_d[i] = any_nz;
    end
    en_d[0] = 1'b1;
  end

  // Sequencer: accept in IDLE/DONE, shift BIN_W times, publish result in DONE for one cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      en_q    <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          valid_q <= 1'b0;
          if (in_valid && ready_q) begin
            shift_q <= bin_in;
            work_q  <= '0;
            cnt_q   <= CNT_LOAD;
            state_q <= SHIFT;
            ready_q <= 1'b0;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        SHIFT: begin
          shift_q <= shift_d;
          work_q  <= work_d;
          if (cnt_q == '0) begin
            // Last shift: the value after this step is the finished result
            state_q <= DONE;
            ready_q <= 1'b1;
            valid_q <= 1'b1;
            bcd_q   <= work_d;
            en_q    <= en_d;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign bcd_out   = bcd_q;
  assign digit_en  = en_q;

endmodule
